// File: rtl/pcie_rx_cred_pkg.sv
// pcie_rx_cred_pkg
// Shared definitions for the PCIe receive credit manager:
//   - TLP class and stream-FSM state enums
//   - TLP header fmt/type constants and header field bit positions
//   - len_dw / dcred helpers (payload length in DW and in 16-byte data credits)
//   - sat_cnt / sat_err helpers for the saturating occupancy counters
package pcie_rx_cred_pkg;

   typedef enum logic [1:0] {
      TLP_P   = 2'd0,
      TLP_NP  = 2'd1,
      TLP_CPL = 2'd2
   } tlp_class_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_IN_TLP = 1'b1
   } rx_state_e;

   // Header field positions within the 64-bit beat (DW0 sits in [63:32])
   localparam int FMT_HI  = 62;
   localparam int FMT_LO  = 61;
   localparam int TYPE_HI = 60;
   localparam int TYPE_LO = 56;
   localparam int TD_BIT  = 47;
   localparam int LEN_HI  = 41;
   localparam int LEN_LO  = 32;

   // fmt bit meanings
   localparam int FMT_4DW_BIT  = 0;
   localparam int FMT_DATA_BIT = 1;

   // type encodings used by the classifier
   localparam logic [1:0] TYPE_MSG_PFX = 2'b10;    // type[4:3], messages are posted
   localparam logic [4:0] TYPE_MEM     = 5'b00000; // memory request (MWr when fmt has data)
   localparam logic [3:0] TYPE_CPL_PFX = 4'b0101;  // type[4:1], completions

   // A length field of zero encodes the maximum of 1024 DW
   function automatic logic [10:0] len_dw(input logic [9:0] len);
      return (len == 10'd0) ? 11'd1024 : {1'b0, len};
   endfunction

   // Data credits consumed by a TLP: ceil(len/4) when it carries data, else 0
   function automatic logic [8:0] dcred(input logic [9:0] len, input logic [1:0] fmt);
      return fmt[FMT_DATA_BIT] ? 9'(({1'b0, len_dw(len)} + 12'd3) >> 2) : 9'd0;
   endfunction

   // Net occupancy after arrival and release, clamped to [0, depth]
   function automatic int sat_cnt(input int used, input int arr, input int rel, input int depth);
      int net;
      net = used + arr - rel;
      if (net < 0)          return 0;
      else if (net > depth) return depth;
      else                  return net;
   endfunction

   function automatic logic sat_err(input int used, input int arr, input int rel, input int depth);
      int net;
      net = used + arr - rel;
      return (net < 0) || (net > depth);
   endfunction

endpackage

// File: rtl/pcie_rx_hdr_decode.sv
// pcie_rx_hdr_decode
// Classifies each received TLP on its start beat, computes the data credits it
// consumes, and runs the stream FSM with a DW-count check.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   data_i, st_i, end_i, dwen_i   VC0 receive stream
//   hdr_valid_o          high on every start beat (combinational)
//   hdr_class_o          tlp_class_e of the start beat (combinational)
//   hdr_dcred_o          data credits of the start beat (combinational)
//   len_err_o            one-cycle pulse after a beat-count mismatch or a
//                        start beat arriving inside a TLP
//   state_o              stream FSM state (0 = IDLE, 1 = IN_TLP)
module pcie_rx_hdr_decode
   import pcie_rx_cred_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [63:0] data_i,
   input  logic        st_i,
   input  logic        end_i,
   input  logic        dwen_i,
   output logic        hdr_valid_o,
   output logic [1:0]  hdr_class_o,
   output logic [8:0]  hdr_dcred_o,
   output logic        len_err_o,
   output logic        state_o
);

   logic [1:0]  fmt;
   logic [4:0]  typ;
   logic        td;
   logic [9:0]  len;
   tlp_class_e  cls;
   logic [10:0] exp_now;
   logic [10:0] beat_dw;

   rx_state_e   state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic [10:0] exp_q, exp_d;
   logic        err_q, err_d;

   logic        unused_data;

   assign fmt = data_i[FMT_HI:FMT_LO];
   assign typ = data_i[TYPE_HI:TYPE_LO];
   assign td  = data_i[TD_BIT];
   assign len = data_i[LEN_HI:LEN_LO];

   // Address, tag and payload bits play no part in credit accounting
   assign unused_data = ^{data_i[63], data_i[55:48], data_i[46:42], data_i[31:0]};

   always_comb begin
      cls = TLP_NP;
      if ((typ[4:3] == TYPE_MSG_PFX) || ((typ == TYPE_MEM) && fmt[FMT_DATA_BIT])) begin
         cls = TLP_P;
      end else if (typ[4:1] == TYPE_CPL_PFX) begin
         cls = TLP_CPL;
      end
   end

   assign hdr_valid_o = st_i;
   assign hdr_class_o = cls;
   assign hdr_dcred_o = dcred(len, fmt);

   // Expected TLP size in DW: header + payload + optional ECRC digest
   assign exp_now = (fmt[FMT_4DW_BIT] ? 11'd4 : 11'd3)
                  + (fmt[FMT_DATA_BIT] ? len_dw(len) : 11'd0)
                  + {10'd0, td};

   // A last beat with dwen set carries only the upper DW
   assign beat_dw = (end_i && dwen_i) ? 11'd1 : 11'd2;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (st_i) begin
               exp_d = exp_now;
               cnt_d = beat_dw;
               if (end_i) err_d = (beat_dw != exp_now);
               else       state_d = ST_IN_TLP;
            end
         end
         ST_IN_TLP: begin
            if (st_i) begin
               // Truncated TLP: flag it and decode the new header from this beat
               err_d   = 1'b1;
               exp_d   = exp_now;
               cnt_d   = beat_dw;
               state_d = end_i ? ST_IDLE : ST_IN_TLP;
            end else if (end_i) begin
               err_d   = ((cnt_q + beat_dw) != exp_q);
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + beat_dw;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         exp_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         err_q   <= err_d;
      end
   end

   assign len_err_o = err_q;
   assign state_o   = state_q;

endmodule

// File: rtl/pcie_rx_credit_ctrl.sv
// pcie_rx_credit_ctrl
// Receive-side credit manager for the x1 PCIe endpoint, VC0.
// Tracks posted / non-posted header and data buffer occupancy, drives the
// core's *_buf_status_vc0 inputs and converts user release handshakes into
// *_processed_vc0 / *_num_vc0 credit-return pulses. Completions are not
// tracked (infinite completion credits are advertised).
// Ports:
//   sys_clk_125, rst_n                 clock, synchronous active-low reset
//   rx_data_vc0, rx_st_vc0, rx_end_vc0, rx_dwen_vc0   receive TLP stream
//   rel_valid, rel_type, rel_dcred, rel_ready         release handshake;
//       a release transfers in every cycle where rel_valid and rel_ready are
//       both high, rel_ready is held high from the first cycle after reset
//   *_buf_status_vc0                   buffer nearly full (registered)
//   *_processed_vc0, pd_num_vc0, npd_num_vc0   credit-return pulses
//   len_err                            TLP beat-count error pulse
//   cred_err                           sticky underflow/overflow flag
//   cnt_p, cnt_np, cnt_cpl             TLP statistics
//   dbg_rx_state_o                     stream FSM state (0 = IDLE, 1 = IN_TLP)
// Build option: define PCIE_RX_CRED_STATS_EN to build the statistics
// counters; otherwise cnt_p/cnt_np/cnt_cpl are tied to 0.
module pcie_rx_credit_ctrl
   import pcie_rx_cred_pkg::*;
#(
   parameter int PH_DEPTH  = 32,
   parameter int PD_DEPTH  = 256,
   parameter int NPH_DEPTH = 16,
   parameter int NPD_DEPTH = 16,
   parameter int HDR_LOW   = 2,
   parameter int MAX_PD    = 32
) (
   input  logic        sys_clk_125,
   input  logic        rst_n,
   input  logic [63:0] rx_data_vc0,
   input  logic        rx_st_vc0,
   input  logic        rx_end_vc0,
   input  logic        rx_dwen_vc0,
   input  logic        rel_valid,
   input  logic        rel_type,
   input  logic [7:0]  rel_dcred,
   output logic        rel_ready,
   output logic        ph_buf_status_vc0,
   output logic        pd_buf_status_vc0,
   output logic        nph_buf_status_vc0,
   output logic        npd_buf_status_vc0,
   output logic        ph_processed_vc0,
   output logic        pd_processed_vc0,
   output logic        nph_processed_vc0,
   output logic        npd_processed_vc0,
   output logic [7:0]  pd_num_vc0,
   output logic [7:0]  npd_num_vc0,
   output logic        len_err,
   output logic        cred_err,
   output logic [15:0] cnt_p,
   output logic [15:0] cnt_np,
   output logic [15:0] cnt_cpl,
   output logic        dbg_rx_state_o
);

   localparam int PH_W  = $clog2(PH_DEPTH + 1);
   localparam int PD_W  = $clog2(PD_DEPTH + 1);
   localparam int NPH_W = $clog2(NPH_DEPTH + 1);
   localparam int NPD_W = $clog2(NPD_DEPTH + 1);

   logic       hdr_valid;
   logic [1:0] hdr_class;
   logic [8:0] hdr_dcred;

   pcie_rx_hdr_decode u_hdr_decode (
      .clk_i       (sys_clk_125),
      .rst_ni      (rst_n),
      .data_i      (rx_data_vc0),
      .st_i        (rx_st_vc0),
      .end_i       (rx_end_vc0),
      .dwen_i      (rx_dwen_vc0),
      .hdr_valid_o (hdr_valid),
      .hdr_class_o (hdr_class),
      .hdr_dcred_o (hdr_dcred),
      .len_err_o   (len_err),
      .state_o     (dbg_rx_state_o)
   );

   logic [PH_W-1:0]  ph_used_q,  ph_used_d;
   logic [PD_W-1:0]  pd_used_q,  pd_used_d;
   logic [NPH_W-1:0] nph_used_q, nph_used_d;
   logic [NPD_W-1:0] npd_used_q, npd_used_d;

   logic       p_arr, np_arr, rel_fire, rel_p, rel_np;
   logic [8:0] pd_arr, npd_arr;
   logic [7:0] pd_rel, npd_rel;
   logic       cnt_err;
   logic       ph_st_d, pd_st_d, nph_st_d, npd_st_d;

   logic rel_ready_q, cred_err_q;
   logic ph_st_q, pd_st_q, nph_st_q, npd_st_q;
   logic ph_proc_q, pd_proc_q, nph_proc_q, npd_proc_q;
   logic [7:0] pd_num_q, npd_num_q;

   always_comb begin
      p_arr    = hdr_valid && (hdr_class == TLP_P);
      np_arr   = hdr_valid && (hdr_class == TLP_NP);
      pd_arr   = p_arr  ? hdr_dcred : 9'd0;
      npd_arr  = np_arr ? hdr_dcred : 9'd0;
      rel_fire = rel_valid && rel_ready_q;
      rel_p    = rel_fire && !rel_type;
      rel_np   = rel_fire &&  rel_type;
      pd_rel   = rel_p  ? rel_dcred : 8'd0;
      npd_rel  = rel_np ? rel_dcred : 8'd0;

      // Arrival and release land in the same cycle as one net update
      ph_used_d  = PH_W'(sat_cnt(int'(ph_used_q), int'(p_arr), int'(rel_p), PH_DEPTH));
      pd_used_d  = PD_W'(sat_cnt(int'(pd_used_q), int'(pd_arr), int'(pd_rel), PD_DEPTH));
      nph_used_d = NPH_W'(sat_cnt(int'(nph_used_q), int'(np_arr), int'(rel_np), NPH_DEPTH));
      npd_used_d = NPD_W'(sat_cnt(int'(npd_used_q), int'(npd_arr), int'(npd_rel), NPD_DEPTH));
      cnt_err    = sat_err(int'(ph_used_q), int'(p_arr), int'(rel_p), PH_DEPTH)
                 | sat_err(int'(pd_used_q), int'(pd_arr), int'(pd_rel), PD_DEPTH)
                 | sat_err(int'(nph_used_q), int'(np_arr), int'(rel_np), NPH_DEPTH)
                 | sat_err(int'(npd_used_q), int'(npd_arr), int'(npd_rel), NPD_DEPTH);

      // Status follows the registered occupancy, hence one cycle behind it
      ph_st_d  = (PH_DEPTH  - int'(ph_used_q))  < HDR_LOW;
      pd_st_d  = (PD_DEPTH  - int'(pd_used_q))  < MAX_PD;
      nph_st_d = (NPH_DEPTH - int'(nph_used_q)) < HDR_LOW;
      npd_st_d = (NPD_DEPTH - int'(npd_used_q)) < 1;
   end

   always_ff @(posedge sys_clk_125) begin
      if (!rst_n) begin
         ph_used_q   <= '0;
         pd_used_q   <= '0;
         nph_used_q  <= '0;
         npd_used_q  <= '0;
         rel_ready_q <= 1'b0;
         cred_err_q  <= 1'b0;
         ph_st_q     <= 1'b0;
         pd_st_q     <= 1'b0;
         nph_st_q    <= 1'b0;
         npd_st_q    <= 1'b0;
         ph_proc_q   <= 1'b0;
         pd_proc_q   <= 1'b0;
         nph_proc_q  <= 1'b0;
         npd_proc_q  <= 1'b0;
         pd_num_q    <= '0;
         npd_num_q   <= '0;
      end else begin
         ph_used_q   <= ph_used_d;
         pd_used_q   <= pd_used_d;
         nph_used_q  <= nph_used_d;
         npd_used_q  <= npd_used_d;
         rel_ready_q <= 1'b1;
         cred_err_q  <= cred_err_q | cnt_err;
         ph_st_q     <= ph_st_d;
         pd_st_q     <= pd_st_d;
         nph_st_q    <= nph_st_d;
         npd_st_q    <= npd_st_d;
         ph_proc_q   <= rel_p;
         pd_proc_q   <= rel_p && (rel_dcred != 8'd0);
         nph_proc_q  <= rel_np;
         npd_proc_q  <= rel_np && (rel_dcred != 8'd0);
         // *_num holds its value between data-credit returns
         if (rel_p && (rel_dcred != 8'd0))  pd_num_q  <= rel_dcred;
         if (rel_np && (rel_dcred != 8'd0)) npd_num_q <= rel_dcred;
      end
   end

   assign rel_ready          = rel_ready_q;
   assign cred_err           = cred_err_q;
   assign ph_buf_status_vc0  = ph_st_q;
   assign pd_buf_status_vc0  = pd_st_q;
   assign nph_buf_status_vc0 = nph_st_q;
   assign npd_buf_status_vc0 = npd_st_q;
   assign ph_processed_vc0   = ph_proc_q;
   assign pd_processed_vc0   = pd_proc_q;
   assign nph_processed_vc0  = nph_proc_q;
   assign npd_processed_vc0  = npd_proc_q;
   assign pd_num_vc0         = pd_num_q;
   assign npd_num_vc0        = npd_num_q;

`ifdef PCIE_RX_CRED_STATS_EN
   logic [15:0] cnt_p_q, cnt_np_q, cnt_cpl_q;

   always_ff @(posedge sys_clk_125) begin
      if (!rst_n) begin
         cnt_p_q   <= '0;
         cnt_np_q  <= '0;
         cnt_cpl_q <= '0;
      end else if (hdr_valid) begin
         // 16-bit counters wrap naturally
         case (hdr_class)
            TLP_P:   cnt_p_q   <= cnt_p_q + 16'd1;
            TLP_NP:  cnt_np_q  <= cnt_np_q + 16'd1;
            TLP_CPL: cnt_cpl_q <= cnt_cpl_q + 16'd1;
            default: ;
         endcase
      end
   end

   assign cnt_p   = cnt_p_q;
   assign cnt_np  = cnt_np_q;
   assign cnt_cpl = cnt_cpl_q;
`else
   assign cnt_p   = 16'd0;
   assign cnt_np  = 16'd0;
   assign cnt_cpl = 16'd0;
`endif

endmodule
